test_result_monitor: RTL and testbench

//  Sits downstream of the RAM test pattern generator; consumes its state[3:0] and compare outputs.

---
 rtl/test_result_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_test_result_monitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/test_result_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : test_result_monitor
// Description : Watches the RAM test pattern generator (state/compare) and
//               frames each test run. Counts compare mismatches, timestamps the
//               first failing cycle, and publishes sticky pass/fail, an error
//               count and a completed-run counter.
// Ports       : clk, reset_n (async, active low)
//               state[3:0]      generator state, 0 = idle
//               compare         generator mismatch flag
//               clear           synchronous clear of sticky results
//               busy/done       run in progress / one-cycle run-closed pulse
//               pass/fail       sticky verdict of the last closed run
//               err_count       saturating mismatch count
//               first_err_cycle run-cycle index of the first mismatch
//               run_count       wrapping count of completed runs
//               timeout         sticky watchdog flag
// Options     : define TEST_MON_TIMEOUT_EN to enable the run watchdog
//               (TIMEOUT_CYCLES); without it timeout is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module test_result_monitor #(
    parameter int ERR_CNT_WIDTH  = 16,
    parameter int CYC_CNT_WIDTH  = 20,
    parameter int RUN_CNT_WIDTH  = 8,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               state,
    input  logic                     compare,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [CYC_CNT_WIDTH-1:0] first_err_cycle,
    output logic [RUN_CNT_WIDTH-1:0] run_count,
    output logic                     timeout
);

    localparam logic [1:0] c_MON_IDLE  = 2'd0;
    localparam logic [1:0] c_MON_RUN   = 2'd1;
    localparam logic [1:0] c_MON_DRAIN = 2'd2;
    localparam logic [1:0] c_MON_DONE  = 2'd3;

    localparam int c_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DRAIN_W-1:0]     c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [c_DRAIN_W-1:0]     c_DRAIN_ONE  = c_DRAIN_W'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_ONE    = ERR_CNT_WIDTH'(1);
    localparam logic [CYC_CNT_WIDTH-1:0] c_CYC_ONE    = CYC_CNT_WIDTH'(1);
    localparam logic [RUN_CNT_WIDTH-1:0] c_RUN_ONE    = RUN_CNT_WIDTH'(1);
    localparam logic [CYC_CNT_WIDTH-1:0] c_TMO_LAST   = CYC_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

`ifdef TEST_MON_TIMEOUT_EN
    localparam logic c_WDOG_EN = 1'b1;
`else
    localparam logic c_WDOG_EN = 1'b0;
`endif

    logic [1:0]               r_fsm, w_fsm_nxt;
    logic                     r_state_zero_d;
    logic [CYC_CNT_WIDTH-1:0] r_cycle_cnt, w_cyc_nxt;
    logic [c_DRAIN_W-1:0]     r_drain_cnt, w_drain_nxt;
    logic                     r_restart, w_restart_nxt;
    logic                     r_busy, w_busy_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_pass, w_pass_nxt;
    logic                     r_fail, w_fail_nxt;
    logic [ERR_CNT_WIDTH-1:0] r_err_count, w_err_nxt;
    logic [CYC_CNT_WIDTH-1:0] r_first_err, w_first_nxt;
    logic [RUN_CNT_WIDTH-1:0] r_run_count, w_runs_nxt;
    logic                     r_timeout, w_timeout_nxt;

    logic w_state_zero, w_start_evt, w_sampling, w_timeout_hit;
    logic w_do_clear, w_do_start, w_do_close;

    // A run starts on the first nonzero state after at least one idle cycle,
    // so a generator stuck at a nonzero state cannot retrigger a run.
    assign w_state_zero  = (state == 4'd0);
    assign w_start_evt   = r_state_zero_d & ~w_state_zero;
    assign w_sampling    = (r_fsm == c_MON_RUN) || (r_fsm == c_MON_DRAIN);
    assign w_timeout_hit = c_WDOG_EN && (r_fsm == c_MON_RUN) && !w_state_zero
                           && (r_cycle_cnt == c_TMO_LAST);

    assign w_do_clear = clear && ((r_fsm == c_MON_IDLE) || (r_fsm == c_MON_DONE));
    assign w_do_start = ((r_fsm == c_MON_IDLE) && w_start_evt)
                        || ((r_fsm == c_MON_DONE) && r_restart);
    // A restart seen during drain closes the current run early.
    assign w_do_close = w_timeout_hit
                        || ((r_fsm == c_MON_DRAIN) && (w_start_evt || (r_drain_cnt == '0)));

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm          <= c_MON_IDLE;
            r_state_zero_d <= 1'b1;
            r_cycle_cnt    <= '0;
            r_drain_cnt    <= '0;
            r_restart      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_err_count    <= '0;
            r_first_err    <= '0;
            r_run_count    <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_fsm          <= w_fsm_nxt;
            r_state_zero_d <= w_state_zero;
            r_cycle_cnt    <= w_cyc_nxt;
            r_drain_cnt    <= w_drain_nxt;
            r_restart      <= w_restart_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_pass         <= w_pass_nxt;
            r_fail         <= w_fail_nxt;
            r_err_count    <= w_err_nxt;
            r_first_err    <= w_first_nxt;
            r_run_count    <= w_runs_nxt;
            r_timeout      <= w_timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            c_MON_IDLE:  if (w_start_evt) w_fsm_nxt = c_MON_RUN;
            c_MON_RUN: begin
                if (w_timeout_hit)     w_fsm_nxt = c_MON_DONE;
                else if (w_state_zero) w_fsm_nxt = c_MON_DRAIN;
            end
            c_MON_DRAIN: if (w_do_close) w_fsm_nxt = c_MON_DONE;
            c_MON_DONE:  w_fsm_nxt = r_restart ? c_MON_RUN : c_MON_IDLE;
            default:     w_fsm_nxt = c_MON_IDLE;
        endcase
    end

    // Next values of counters and registered outputs
    always_comb begin
        w_cyc_nxt     = r_cycle_cnt;
        w_drain_nxt   = r_drain_cnt;
        w_restart_nxt = r_restart;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_err_nxt     = r_err_count;
        w_first_nxt   = r_first_err;
        w_runs_nxt    = r_run_count;
        w_timeout_nxt = r_timeout;

        if (w_sampling) begin
            if (r_cycle_cnt != '1) w_cyc_nxt = r_cycle_cnt + c_CYC_ONE;
            if (compare) begin
                if (r_err_count != '1) w_err_nxt = r_err_count + c_ERR_ONE;
                if (r_err_count == '0) w_first_nxt = r_cycle_cnt;
            end
        end

        if ((r_fsm == c_MON_RUN) && w_state_zero)
            w_drain_nxt = c_DRAIN_LOAD;
        if ((r_fsm == c_MON_DRAIN) && (r_drain_cnt != '0))
            w_drain_nxt = r_drain_cnt - c_DRAIN_ONE;

        if (w_timeout_hit) w_timeout_nxt = 1'b1;

        // Verdict includes a mismatch seen on the closing cycle itself.
        if (w_do_close) begin
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
            w_pass_nxt    = (w_err_nxt == '0) && !w_timeout_nxt;
            w_fail_nxt    = !((w_err_nxt == '0) && !w_timeout_nxt);
            w_runs_nxt    = r_run_count + c_RUN_ONE;
            w_restart_nxt = (r_fsm == c_MON_DRAIN) && w_start_evt;
        end

        if (w_do_clear) begin
            w_pass_nxt    = 1'b0;
            w_fail_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
            w_err_nxt     = '0;
            w_first_nxt   = '0;
            w_runs_nxt    = '0;
        end

        if (w_do_start) begin
            w_err_nxt     = '0;
            w_first_nxt   = '0;
            w_cyc_nxt     = '0;
            w_pass_nxt    = 1'b0;
            w_fail_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
            w_busy_nxt    = 1'b1;
            w_restart_nxt = 1'b0;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign fail            = r_fail;
    assign err_count       = r_err_count;
    assign first_err_cycle = r_first_err;
    assign run_count       = r_run_count;
    assign timeout         = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_test_result_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_test_result_monitor
// Description : Scoreboard bench for test_result_monitor. Stimulus pushes the
//               hand-computed result of each run; a monitor pops and compares
//               on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_result_monitor;

    localparam int ERR_W = 4;
    localparam int CYC_W = 20;
    localparam int RUN_W = 8;
    localparam int DRAIN = 4;
    localparam int TMO   = 64;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       state;
    logic             compare;
    logic             clear;
    logic             busy, done, pass, fail, timeout;
    logic [ERR_W-1:0] err_count;
    logic [CYC_W-1:0] first_err_cycle;
    logic [RUN_W-1:0] run_count;

    test_result_monitor #(
        .ERR_CNT_WIDTH  (ERR_W),
        .CYC_CNT_WIDTH  (CYC_W),
        .RUN_CNT_WIDTH  (RUN_W),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .state           (state),
        .compare         (compare),
        .clear           (clear),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail            (fail),
        .err_count       (err_count),
        .first_err_cycle (first_err_cycle),
        .run_count       (run_count),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int err;
        int first;   // -1: not checked
        int pass;
        int fail;
        int runs;
        int tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total    = 0;
    int   bad      = 0;
    int   rc_model = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int at, input int err, input int first,
                            input int p, input int f, input int tmo);
        exp_t e;
        rc_model = (rc_model + 1) % 256;
        e.at = at; e.err = err; e.first = first;
        e.pass = p; e.fail = f; e.runs = rc_model; e.tmo = tmo;
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_pass"},  32'(pass), 0);
        chk({tag, "_fail"},  32'(fail), 0);
        chk({tag, "_err"},   32'(err_count), 0);
        chk({tag, "_first"}, 32'(first_err_cycle), 0);
        chk({tag, "_runs"},  32'(run_count), 0);
        chk({tag, "_tmo"},   32'(timeout), 0);
    endtask

    // Run of len nonzero-state cycles starting now. cmp_mask[k] drives compare
    // when the run cycle counter reads k. Done is due DRAIN+1 cycles after the
    // first zero-state cycle.
    task automatic run(input int len, input logic [127:0] cmp_mask, input int clr_j,
                       input int e_err, input int e_first, input int e_pass);
        int s;
        s = cyc;
        push_exp(s + len + DRAIN + 1, e_err, e_first, e_pass, 1 - e_pass, 0);
        for (int j = 0; j <= len + DRAIN + 2; j++) begin
            state   = (j < len) ? 4'(1 + (j * 8) / len) : 4'd0;
            compare = (j >= 1) ? cmp_mask[j-1] : 1'b0;
            clear   = (j == clr_j);
            if (j == 2) chk("busy_in_run", 32'(busy), 1);
            tick();
        end
        compare = 1'b0;
        clear   = 1'b0;
    endtask

    // Monitor: compares every done pulse against the scoreboard head
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("done_without_run", 32'(done), 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_cycle", cyc, mon_e.at);
                    chk("err_count", 32'(err_count), mon_e.err);
                    if (mon_e.first >= 0)
                        chk("first_err_cycle", 32'(first_err_cycle), mon_e.first);
                    chk("pass", 32'(pass), mon_e.pass);
                    chk("fail", 32'(fail), mon_e.fail);
                    chk("run_count", 32'(run_count), mon_e.runs);
                    chk("timeout", 32'(timeout), mon_e.tmo);
                    chk("busy_at_done", 32'(busy), 0);
                end
            end else if (sb.size() != 0 && cyc > sb[0].at) begin
                chk("done_missing", 32'(done), 1);
                mon_e = sb.pop_front();
            end
        end
    end

    initial begin
        logic [127:0] m;
        int s;
        reset_n = 1'b0;
        state   = 4'd0;
        compare = 1'b0;
        clear   = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        reset_n = 1'b1;
        tick();
        tick();

        // Clean run: 120 cycles stepping state 1..8
        m = '0;
        run(120, m, -1, 0, 0, 1);

        // Errors at run cycles 40, 41, 90
        m = '0; m[40] = 1'b1; m[41] = 1'b1; m[90] = 1'b1;
        run(120, m, -1, 3, 40, 0);

        // Mismatch on the last drain cycle is counted
        m = '0; m[23] = 1'b1;
        run(20, m, -1, 1, -1, 0);

        // Mismatch on the done cycle is ignored
        m = '0; m[24] = 1'b1;
        run(20, m, -1, 0, 0, 1);

        // 20 mismatches saturate a 4-bit counter at 15
        m = '0; m[19:0] = '1;
        run(30, m, -1, 15, 0, 0);

        // Clear during run has no effect
        m = '0; m[3] = 1'b1;
        run(30, m, 5, 1, 3, 0);

        // Clear in idle zeroes all results
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rc_model = 0;
        chk_zero("clear_idle");

        // Restart during drain: run A closes early, run B follows immediately
        s = cyc;
        push_exp(s + 23, 1, 2, 0, 1, 0);
        push_exp(s + 37, 0, 0, 1, 0, 0);
        for (int j = 0; j <= 40; j++) begin
            state   = ((j < 20) || (j >= 22 && j < 32)) ? 4'd3 : 4'd0;
            compare = (j == 3);
            if (j == 24) begin
                chk("restart_busy", 32'(busy), 1);
                chk("restart_err", 32'(err_count), 0);
                chk("restart_pass", 32'(pass), 0);
                chk("restart_fail", 32'(fail), 0);
            end
            tick();
        end
        compare = 1'b0;

        // 254 more runs -> 256 since clear, run counter wraps to 0
        m = '0;
        for (int r = 0; r < 254; r++) run(1, m, -1, 0, 0, 1);
        chk("run_count_wrap", 32'(run_count), 0);

`ifdef TEST_MON_TIMEOUT_EN
        // Hung generator: watchdog closes the run and it does not retrigger
        s = cyc;
        push_exp(s + 65, 0, 0, 0, 1, 1);
        for (int j = 0; j < 100; j++) begin
            state = 4'd6;
            if (j == 80) chk("timeout_no_retrigger", 32'(busy), 0);
            tick();
        end
        state = 4'd0;
        tick();
        tick();
        m = '0;
        run(5, m, -1, 0, 0, 1);
`endif

        // Reset mid-run discards the partial run
        for (int j = 0; j < 10; j++) begin
            state = 4'd2;
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk_zero("reset_mid");
        state = 4'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        rc_model = 0;
        m = '0;
        run(3, m, -1, 0, 0, 1);

        for (int w = 0; w < 20 && sb.size() != 0; w++) tick();
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
